// File: rtl/digit_scan_ctrl.sv
// Two-digit seven-segment scan controller: alternates ones/tens anodes with a
// blanking gap before each slot, optional tens leading-zero blanking, frame tick.
module digit_scan_ctrl #(
  parameter int unsigned ON_CYCLES    = 49000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       En,
  input  logic       LeadZeroBlank,
  input  logic       TensIsZero,
  output logic       S0,
  output logic [1:0] An,
  output logic       Blank,
  output logic       FrameTick
);

  localparam int unsigned MAX_LEN = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [1:0] ST_BLANK_TO_ONES = 2'd0;
  localparam logic [1:0] ST_ONES_ON       = 2'd1;
  localparam logic [1:0] ST_BLANK_TO_TENS = 2'd2;
  localparam logic [1:0] ST_TENS_ON       = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] slot_last;
  logic             lz_hold, lz_nxt;
  logic             s0_nxt, blank_nxt, ft_nxt;
  logic [1:0]       an_nxt;

  // State register; outputs are registered alongside the state they decode.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_BLANK_TO_ONES;
      cnt       <= '0;
      lz_hold   <= 1'b0;
      S0        <= 1'b0;
      An        <= 2'b11;
      Blank     <= 1'b1;
      FrameTick <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lz_hold   <= lz_nxt;
      S0        <= s0_nxt;
      An        <= an_nxt;
      Blank     <= blank_nxt;
      FrameTick <= ft_nxt;
    end
  end

  // Slot sequencing, then decode of the outputs for the state being entered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    lz_nxt    = lz_hold;
    ft_nxt    = 1'b0;
    s0_nxt    = 1'b0;
    an_nxt    = 2'b11;
    blank_nxt = 1'b1;

    slot_last = ((state == ST_ONES_ON) || (state == ST_TENS_ON)) ? ON_LAST : BLANK_LAST;

    if (cnt == slot_last) begin
      cnt_nxt = '0;
      case (state)
        ST_BLANK_TO_ONES: state_nxt = ST_ONES_ON;
        ST_ONES_ON:       state_nxt = ST_BLANK_TO_TENS;
        ST_BLANK_TO_TENS: state_nxt = ST_TENS_ON;
        ST_TENS_ON:       state_nxt = ST_BLANK_TO_ONES;
        default:          state_nxt = ST_BLANK_TO_ONES;
      endcase
    end

    // Leading-zero decision is frozen for the whole tens slot.
    if ((state == ST_BLANK_TO_TENS) && (state_nxt == ST_TENS_ON))
      lz_nxt = LeadZeroBlank & TensIsZero;

    ft_nxt = (state == ST_TENS_ON) && (state_nxt == ST_BLANK_TO_ONES);

    if (!En) begin
      state_nxt = ST_BLANK_TO_ONES;
      cnt_nxt   = '0;
      ft_nxt    = 1'b0;
    end

    case (state_nxt)
      ST_BLANK_TO_ONES: begin
        s0_nxt    = 1'b0;
        an_nxt    = 2'b11;
        blank_nxt = 1'b1;
      end
      ST_ONES_ON: begin
        s0_nxt    = 1'b0;
        an_nxt    = 2'b10;
        blank_nxt = 1'b0;
      end
      ST_BLANK_TO_TENS: begin
        s0_nxt    = 1'b1;
        an_nxt    = 2'b11;
        blank_nxt = 1'b1;
      end
      ST_TENS_ON: begin
        s0_nxt    = 1'b1;
        an_nxt    = lz_nxt ? 2'b11 : 2'b01;
        blank_nxt = 1'b0;
      end
      default: begin
        s0_nxt    = 1'b0;
        an_nxt    = 2'b11;
        blank_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: a frame-position model (cycles since
// restart, modulo frame length) predicts every output cycle by cycle.
module tb_digit_scan_ctrl;

  localparam int unsigned ON    = 4;
  localparam int unsigned BL    = 2;
  localparam int          FRAME = 2 * (ON + BL);

  logic       Clk;
  logic       Reset_n;
  logic       En;
  logic       LeadZeroBlank;
  logic       TensIsZero;
  logic       S0;
  logic [1:0] An;
  logic       Blank;
  logic       FrameTick;

  int n_checks;
  int n_fail;

  digit_scan_ctrl #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .En           (En),
    .LeadZeroBlank(LeadZeroBlank),
    .TensIsZero   (TensIsZero),
    .S0           (S0),
    .An           (An),
    .Blank        (Blank),
    .FrameTick    (FrameTick)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference: t = cycles since last restart; lz = tens-blank decision of the current frame.
  int t;
  bit lz;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      t  <= 0;
      lz <= 1'b0;
    end else if (!En) begin
      t <= 0;
    end else begin
      t <= t + 1;
      if (((t + 1) % FRAME) == (2 * BL + ON)) lz <= LeadZeroBlank & TensIsZero;
    end
  end

  int         p;
  logic       e_s0;
  logic [1:0] e_an;
  logic       e_blank;
  logic       e_ft;
  always_comb begin
    p       = t % FRAME;
    e_ft    = (p == 0) && (t != 0);
    e_s0    = 1'b0;
    e_an    = 2'b11;
    e_blank = 1'b1;
    if (p < BL) begin
      e_s0 = 1'b0; e_an = 2'b11; e_blank = 1'b1;
    end else if (p < BL + ON) begin
      e_s0 = 1'b0; e_an = 2'b10; e_blank = 1'b0;
    end else if (p < 2 * BL + ON) begin
      e_s0 = 1'b1; e_an = 2'b11; e_blank = 1'b1;
    end else begin
      e_s0 = 1'b1; e_an = lz ? 2'b11 : 2'b01; e_blank = 1'b0;
    end
  end

  task automatic wait_phase(input int ph, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge Clk);
      if (p == ph) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; En = 1'b0; LeadZeroBlank = 1'b0; TensIsZero = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks++;
    if ({S0, An, Blank, FrameTick} !== 5'b0_11_1_0) begin
      n_fail++;
      $display("FAIL reset_values: got S0=%b An=%b Blank=%b FT=%b, want S0=0 An=11 Blank=1 FT=0",
               S0, An, Blank, FrameTick);
    end
  endtask

  task automatic test_scan();
    En = 1'b1; LeadZeroBlank = 1'b0; TensIsZero = 1'b0;
    Reset_n = 1'b1;
    for (int c = 0; c < 3 * FRAME + 1; c++) begin
      if (c != 0) @(negedge Clk);
      else #1;
      n_checks++;
      if ({S0, An, Blank, FrameTick} !== {e_s0, e_an, e_blank, e_ft}) begin
        n_fail++;
        $display("FAIL scan_c%0d: got S0=%b An=%b Blank=%b FT=%b, want S0=%b An=%b Blank=%b FT=%b",
                 c, S0, An, Blank, FrameTick, e_s0, e_an, e_blank, e_ft);
      end
    end
    // cycle 3*FRAME of the restart: frame tick with ones-blank outputs
    n_checks++;
    if ({FrameTick, An, S0} !== 4'b1_11_0) begin
      n_fail++;
      $display("FAIL scan_frame_tick: got FT=%b An=%b S0=%b, want FT=1 An=11 S0=0", FrameTick, An, S0);
    end
  endtask

  task automatic test_lead_zero();
    bit ok;
    LeadZeroBlank = 1'b1; TensIsZero = 1'b1;
    wait_phase(2 * BL + ON + 1, ok);   // second cycle of a tens slot sampled before this change
    wait_phase(2 * BL + ON + 1, ok);   // now inside a tens slot that sampled TensIsZero=1
    n_checks++;
    if (!ok || An !== 2'b11 || S0 !== 1'b1) begin
      n_fail++;
      $display("FAIL lz_suppressed: got An=%b S0=%b ok=%0d, want An=11 S0=1", An, S0, ok);
    end
    TensIsZero = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge Clk);
      n_checks++;
      if ({S0, An, Blank, FrameTick} !== {e_s0, e_an, e_blank, e_ft}) begin
        n_fail++;
        $display("FAIL lz_c%0d: got S0=%b An=%b Blank=%b FT=%b, want S0=%b An=%b Blank=%b FT=%b",
                 c, S0, An, Blank, FrameTick, e_s0, e_an, e_blank, e_ft);
      end
      if (c == 1) begin
        n_checks++;
        if (An !== 2'b11) begin
          n_fail++;
          $display("FAIL lz_held_mid_slot: got An=%b, want 11", An);
        end
      end
    end
    wait_phase(2 * BL + ON, ok);
    n_checks++;
    if (!ok || An !== 2'b01) begin
      n_fail++;
      $display("FAIL lz_next_frame: got An=%b ok=%0d, want 01", An, ok);
    end
    LeadZeroBlank = 1'b0;
  endtask

  task automatic test_en_drop();
    bit ok;
    wait_phase(2 * BL + ON + 2, ok);   // third cycle of TENS_ON
    En = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      n_checks++;
      if (!ok || {S0, An, Blank, FrameTick} !== 5'b0_11_1_0) begin
        n_fail++;
        $display("FAIL en_low_c%0d: got S0=%b An=%b Blank=%b FT=%b ok=%0d, want S0=0 An=11 Blank=1 FT=0",
                 c, S0, An, Blank, FrameTick, ok);
      end
    end
    En = 1'b1;
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(negedge Clk);
      n_checks++;
      if ({S0, An, Blank, FrameTick} !== {e_s0, e_an, e_blank, e_ft}) begin
        n_fail++;
        $display("FAIL en_restart_c%0d: got S0=%b An=%b Blank=%b FT=%b, want S0=%b An=%b Blank=%b FT=%b",
                 c, S0, An, Blank, FrameTick, e_s0, e_an, e_blank, e_ft);
      end
      if (c == BL) begin
        n_checks++;
        if (An !== 2'b10) begin
          n_fail++;
          $display("FAIL en_restart_ones: got An=%b, want 10", An);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_phase(BL + 1, ok);            // mid ONES_ON
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || An !== 2'b11 || S0 !== 1'b0 || Blank !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got An=%b S0=%b Blank=%b ok=%0d, want An=11 S0=0 Blank=1",
               An, S0, Blank, ok);
    end
    @(negedge Clk);
    #1 Reset_n = 1'b1;
    for (int c = 0; c < FRAME + 1; c++) begin
      @(negedge Clk);
      n_checks++;
      if ({S0, An, Blank, FrameTick} !== {e_s0, e_an, e_blank, e_ft}) begin
        n_fail++;
        $display("FAIL rst_restart_c%0d: got S0=%b An=%b Blank=%b FT=%b, want S0=%b An=%b Blank=%b FT=%b",
                 c, S0, An, Blank, FrameTick, e_s0, e_an, e_blank, e_ft);
      end
    end
  endtask

  task automatic test_random();
    logic prev_s0, prev_ft;
    prev_s0 = S0;
    prev_ft = FrameTick;
    for (int c = 0; c < 1000; c++) begin
      En            = ($urandom_range(0, 19) != 0);
      TensIsZero    = $urandom_range(0, 1) == 1;
      LeadZeroBlank = $urandom_range(0, 1) == 1;
      @(negedge Clk);
      n_checks++;
      if ({S0, An, Blank, FrameTick} !== {e_s0, e_an, e_blank, e_ft}) begin
        n_fail++;
        $display("FAIL rand_c%0d: got S0=%b An=%b Blank=%b FT=%b, want S0=%b An=%b Blank=%b FT=%b",
                 c, S0, An, Blank, FrameTick, e_s0, e_an, e_blank, e_ft);
      end
      n_checks++;
      if (An === 2'b00) begin
        n_fail++;
        $display("FAIL rand_both_anodes_c%0d: got An=%b, want not 00", c, An);
      end
      n_checks++;
      if ((S0 !== prev_s0) && !(Blank === 1'b1 && An === 2'b11)) begin
        n_fail++;
        $display("FAIL rand_s0_toggle_c%0d: got Blank=%b An=%b on S0 change, want Blank=1 An=11", c, Blank, An);
      end
      n_checks++;
      if (prev_ft === 1'b1 && FrameTick === 1'b1) begin
        n_fail++;
        $display("FAIL rand_ft_double_c%0d: got FT high two cycles, want single pulse", c);
      end
      prev_s0 = S0;
      prev_ft = FrameTick;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_scan();
    test_lead_zero();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
